// File: rtl/dmem_waitstate.sv
// Word-organised big-endian data RAM with byte enables and a wait-state FSM.
// Optional range checking with `err` output when DMEM_RANGE_CHECK_EN is defined.
module dmem_waitstate #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   WriteData,
    input  logic [DATA_W/8-1:0] ByteEn,
    input  logic                MemRead,
    input  logic                MemWrite,
    output logic [DATA_W-1:0]   ReadData,
    output logic                ready
`ifdef DMEM_RANGE_CHECK_EN
    ,
    output logic                err
`endif
);

    localparam int NB   = DATA_W / 8;
    localparam int LSB  = $clog2(NB);
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NB-1:0]     be_q;
    logic              wr_q;

    logic              idle;
    logic              req;
    logic              commit;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic [NB-1:0]     op_be;
    logic              op_wr;
    logic [ADDR_W-1:0] off;
    logic [IDXW-1:0]   idx;
    logic [DATA_W-1:0] rd_nxt;
    logic              wr_en;

    assign idle = (state == IDLE);
    assign req  = MemRead | MemWrite;

    // With zero wait states the access commits on its accepting edge,
    // so the live inputs feed the datapath while idle.
    assign op_addr  = idle ? address   : addr_q;
    assign op_wdata = idle ? WriteData : wdata_q;
    assign op_be    = idle ? ByteEn    : be_q;
    assign op_wr    = idle ? MemWrite  : wr_q;

    assign commit = (idle && req && (WAIT_CYCLES == 0))
                  || (state == BUSY && cnt == 4'd1);

    assign off = op_addr - ADDR_W'(BASE_ADDR);
    assign idx = IDXW'((off >> LSB) % ADDR_W'(DEPTH));

`ifdef DMEM_RANGE_CHECK_EN
    logic in_range;
    assign in_range = (op_addr >= ADDR_W'(BASE_ADDR))
                    && (off < ADDR_W'(DEPTH * NB));
    assign wr_en = rst && commit && op_wr && in_range;
`else
    assign wr_en = rst && commit && op_wr;
`endif

    always_comb begin
        rd_nxt = mem[idx];
        if (op_wr)
            rd_nxt = '0;
`ifdef DMEM_RANGE_CHECK_EN
        if (!in_range)
            rd_nxt = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (op_be[b])
                    mem[idx][b*8 +: 8] <= op_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            wr_q     <= 1'b0;
            ReadData <= '0;
`ifdef DMEM_RANGE_CHECK_EN
            err      <= 1'b0;
`endif
        end else begin
            if (commit)
                ReadData <= rd_nxt;
`ifdef DMEM_RANGE_CHECK_EN
            err <= commit && !in_range;
`endif
            unique case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= address;
                        wdata_q <= WriteData;
                        be_q    <= ByteEn;
                        wr_q    <= MemWrite;
                        cnt     <= 4'(WAIT_CYCLES);
                        state   <= (WAIT_CYCLES == 0) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ready = (state == DONE);

endmodule

// File: tb/tb_dmem_waitstate.sv
// Randomised bench for dmem_waitstate against an array-based memory model.
// Two instances: WAIT_CYCLES=2 (main) and WAIT_CYCLES=0.
module tb_dmem_waitstate;

    localparam int DEPTH = 64;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] WriteData;
    logic [3:0]  ByteEn;
    logic        rd2, wr2, rd0, wr0;
    logic [31:0] rdata2, rdata0;
    logic        rdy2, rdy0;
`ifdef DMEM_RANGE_CHECK_EN
    logic        err2, err0;
`endif

    logic [31:0] m2 [DEPTH];
    logic [31:0] m0 [DEPTH];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_waitstate #(.WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .address(address),
        .WriteData(WriteData), .ByteEn(ByteEn),
        .MemRead(rd2), .MemWrite(wr2),
        .ReadData(rdata2), .ready(rdy2)
`ifdef DMEM_RANGE_CHECK_EN
        , .err(err2)
`endif
    );

    dmem_waitstate #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .address(address),
        .WriteData(WriteData), .ByteEn(ByteEn),
        .MemRead(rd0), .MemWrite(wr0),
        .ReadData(rdata0), .ready(rdy0)
`ifdef DMEM_RANGE_CHECK_EN
        , .err(err0)
`endif
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off / 4) % DEPTH);
    endfunction

    function automatic bit oob_of(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
        return (a < BASE) || (a >= BASE + DEPTH * 4);
`else
        return 1'b0;
`endif
    endfunction

    // One full access on instance sel (1 = zero-wait), checked vs model.
    task automatic access(input bit sel, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic [31:0] got);
        int cyc, lat, idx;
        bit oob;
        logic [31:0] exp_rd, w;
        idx = widx(a);
        oob = oob_of(a);
        lat = sel ? 1 : 3;
        w = sel ? m0[idx] : m2[idx];
        exp_rd = (!wr && !oob) ? w : 32'h0;
        if (wr && !oob) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) w[b*8 +: 8] = d[b*8 +: 8];
            if (sel) m0[idx] = w;
            else     m2[idx] = w;
        end
        @(negedge clk);
        address = a; WriteData = d; ByteEn = be;
        if (sel) begin rd0 = rd; wr0 = wr; end
        else     begin rd2 = rd; wr2 = wr; end
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (sel ? rdy0 : rdy2) break;
            address   = $urandom;
            WriteData = $urandom;
            ByteEn    = 4'($urandom);
        end
        check("latency", cyc, lat);
        got = sel ? rdata0 : rdata2;
        check("rdata", got, exp_rd);
`ifdef DMEM_RANGE_CHECK_EN
        check("err", sel ? err0 : err2, {31'b0, oob});
`endif
        rd0 = 0; wr0 = 0; rd2 = 0; wr2 = 0;
        @(negedge clk);
        check("ready_low", sel ? rdy0 : rdy2, 0);
    endtask

    initial begin
        logic [31:0] got, a, d;
        int cyc, op;
        for (int i = 0; i < DEPTH; i++) begin
            m2[i] = 0;
            m0[i] = 0;
        end
        rst = 0; address = BASE; WriteData = 0; ByteEn = 0;
        rd2 = 1; wr2 = 0; rd0 = 0; wr0 = 0;

        // Reset held with a pending read
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_ready", rdy2, 0);
            check("rst_rdata", rdata2, 0);
        end
        rst = 1;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (rdy2) break;
        end
        check("first_lat", cyc, 3);
        rd2 = 0;
        @(negedge clk);

        // Preload both RAMs with zeros
        for (int i = 0; i < DEPTH; i++) begin
            access(0, 0, 1, BASE + 4 * i, 0, 4'hF, got);
            access(1, 0, 1, BASE + 4 * i, 0, 4'hF, got);
        end

        access(0, 0, 1, 1024, 32'hDEADBEEF, 4'hF, got);
        access(0, 1, 0, 1024, 0, 4'h0, got);
        check("deadbeef", got, 32'hDEADBEEF);

        access(0, 0, 1, 1028, 32'h11223344, 4'hF, got);
        access(0, 0, 1, 1028, 32'hAABBCCDD, 4'b1001, got);
        access(0, 1, 0, 1028, 0, 4'hF, got);
        check("byte_en", got, 32'hAA2233DD);

        access(0, 0, 1, 1032, 32'h12345678, 4'h0, got);
        access(0, 1, 0, 1032, 0, 4'hF, got);
        check("be_zero", got, 32'h0);

        // Zero wait states: back-to-back reads, one idle cycle apart
        access(1, 0, 1, 1032, 32'hCAFEF00D, 4'hF, got);
        @(negedge clk);
        address = 1032; rd0 = 1;
        #1 check("w0_c0", rdy0, 0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check("w0_rdy", rdy0, k % 2);
            if (k % 2 == 1) check("w0_data", rdata0, 32'hCAFEF00D);
        end
        rd0 = 0;
        @(negedge clk);

        // Reset while BUSY aborts the write
        @(negedge clk);
        address = 1036; WriteData = 32'h55; ByteEn = 4'hF; wr2 = 1;
        @(negedge clk);
        rst = 0; wr2 = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_ready", rdy2, 0);
        end
        rst = 1;
        access(0, 1, 0, 1036, 0, 4'hF, got);
        check("abort_data", got, 32'h0);

        // Range boundary / wrap-around
        access(0, 0, 1, BASE + DEPTH * 4, 32'h0BADF00D, 4'hF, got);
        access(0, 1, 0, 1024, 0, 4'hF, got);
`ifdef DMEM_RANGE_CHECK_EN
        check("word0_kept", got, 32'hDEADBEEF);
`else
        check("word0_wrap", got, 32'h0BADF00D);
`endif
        access(0, 1, 0, 1020, 0, 4'hF, got);

        // Random mix on both instances
        for (int i = 0; i < 120; i++) begin
            op = $urandom_range(0, 3);
            a = BASE + 4 * $urandom_range(0, DEPTH - 1)
                + $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0)
                a = a + DEPTH * 4;
            else if ($urandom_range(0, 7) == 0)
                a = BASE - 4 * $urandom_range(1, 8);
            d = $urandom;
            access(i % 3 == 0, op != 1, op == 1 || op == 2,
                   a, d, 4'($urandom), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_waitstate.md
Name: dmem_waitstate

Overview:
- Parametrised successor to the single-cycle data memory in the MEM stage.
- Word-organised, base-offset data RAM with per-byte write enables and a programmable wait-state FSM.
- Drives a real `ready` handshake so the pipeline freeze logic can model slow memory.
- Big-endian byte order, as in the current data memory: the byte at the lowest address sits in the most significant bits.

Parameters:
- ADDR_W, 32: width of `address`.
- DATA_W, 32: word width; must be a multiple of 8. NB = DATA_W/8.
- DEPTH, 64: number of words stored.
- BASE_ADDR, 1024: byte address that maps to word 0.
- WAIT_CYCLES, 2: extra cycles between request acceptance and `ready`. Legal range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- address  in  ADDR_W  byte address; low log2(NB) bits ignored (word aligned).
- WriteData  in  DATA_W  store data.
- ByteEn  in  NB  per-byte write enable; ByteEn[NB-1] selects WriteData[DATA_W-1:DATA_W-8], the lowest-address byte.
- MemRead  in  1  read request, held until `ready`.
- MemWrite  in  1  write request, held until `ready`.
- ReadData  out  DATA_W  read result.
- ready  out  1  one-cycle completion pulse.

Behaviour:
- Word index = (address - BASE_ADDR) >> log2(NB), taken modulo DEPTH (wrap-around) when the range check is compiled out.
- Reset, sampled on the rising clk edge while rst=0:
  - state=IDLE, ready=0, ReadData=0, wait counter=0, all latches cleared.
  - RAM contents are not reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Samples MemRead/MemWrite each edge.
  - If either is high: latch address, WriteData, ByteEn and the op. Load the counter with WAIT_CYCLES.
  - Go to BUSY, or to DONE directly if WAIT_CYCLES=0.
  - MemRead and MemWrite both high: treated as a write; ReadData returns 0.
- BUSY:
  - Counter decrements each edge.
  - On the edge where counter==1 the commit happens and the FSM enters DONE:
    - Write: update only the enabled bytes of the latched word.
    - Read: capture the full word into ReadData.
  - Request inputs are ignored in BUSY. Changing them mid-op has no effect.
- DONE:
  - ready=1 for exactly this one cycle. Next edge returns to IDLE.
  - A request still or newly asserted in that next IDLE cycle starts a new access. Back-to-back accesses therefore have one idle cycle between them.
- Latency: ready rises WAIT_CYCLES+1 cycles after the accepting edge.
  - WAIT_CYCLES=0: ready is high in the cycle after the request is first sampled.
- ReadData:
  - Holds the last read value until the next read commit.
  - Write and both-high ops load 0.
  - ReadData is registered. There is no combinational path from address.
- ByteEn is ignored for reads. A write with ByteEn=0 completes normally (ready pulses) and changes nothing.
- Reset mid-operation: an access in BUSY is aborted with no write and no ready. An access in DONE has already committed.
- A read after a write to the same word, in the next access, returns the new data. There is no read-during-write hazard, because accesses are serialised.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- Defined:
  - Adds output `err` (1 bit, reset 0).
  - An access whose address < BASE_ADDR or >= BASE_ADDR + DEPTH*NB still runs the full FSM timing.
  - On such an access: no write occurs, ReadData loads 0, and err=1 in the same cycle as ready (one cycle only).
- Not defined:
  - No `err` port.
  - Out-of-range indices wrap modulo DEPTH.

Test Plan:
- Reset: rst=0 for 2 edges with MemRead=1 -> ready=0 and ReadData=0 throughout. After release, the first read starts only then.
- Default params, write 0xDEADBEEF to 1024 with ByteEn=4'hF -> ready pulses exactly 3 cycles after the accepting edge. A following read of 1024 returns 0xDEADBEEF with ready at the same latency.
- Byte enables: word at 1028 = 0x11223344. Write 0xAABBCCDD with ByteEn=4'b1001 -> a read returns 0xAA2233DD.
- WAIT_CYCLES=0: hold MemRead=1 for 4 cycles at 1032 -> ready pattern 0,1,0,1 (one-idle-cycle serialisation). The data is valid on each pulse.
- Reset mid-op: write 0x55 (ByteEn=4'hF) to 1036, pull rst low while BUSY -> no ready. A read after reset returns the prior contents (pre-loaded 0x0).
- DMEM_RANGE_CHECK_EN defined: read address 1020 -> ready and err high together, ReadData=0. Write 1024+DEPTH*4 -> err=1 and word 0 unchanged. Macro undefined: write at 1024+DEPTH*4 lands in word 0.
